// File: rtl/stack_mips_controller.sv
// Multi-cycle Moore control FSM for the stack-based 8-bit MIPS core: sequences fetch/decode/execute
// for the eight stack instructions. Outputs decode the current state only and are forced low while rst is high.
module stack_mips_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] OPC,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       StackSrc,
    output logic       ldA,
    output logic       ldB,
    output logic [1:0] ALUSrcA,
    output logic       ALUSrcB,
    output logic       PCSrc,
    output logic [1:0] ALUControl
);

    typedef enum logic [4:0] {
        S_IF    = 5'd0,
        S_ID    = 5'd1,
        S_POPA  = 5'd2,
        S_POPB  = 5'd3,
        S_LDB   = 5'd4,
        S_EXE   = 5'd5,
        S_PUSHR = 5'd6,
        S_POPN  = 5'd7,
        S_LDBN  = 5'd8,
        S_EXEN  = 5'd9,
        S_MEMRD = 5'd10,
        S_PUSHM = 5'd11,
        S_POPM  = 5'd12,
        S_LDAM  = 5'd13,
        S_MEMWR = 5'd14,
        S_JMP   = 5'd15,
        S_TOS   = 5'd16,
        S_LDAZ  = 5'd17,
        S_JZ    = 5'd18
    } state_e;

    // Plain vector so the 13 unused encodings stay representable and recover to IF.
    logic [4:0] state_q;
    logic [4:0] state_d;

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                case (OPC)
                    3'b000, 3'b001, 3'b010: state_d = S_POPA;
                    3'b011:                 state_d = S_POPN;
                    3'b100:                 state_d = S_MEMRD;
                    3'b101:                 state_d = S_POPM;
                    3'b110:                 state_d = S_JMP;
                    3'b111:                 state_d = S_TOS;
                endcase
            end
            S_POPA:  state_d = S_POPB;
            S_POPB:  state_d = S_LDB;
            S_LDB:   state_d = S_EXE;
            S_EXE:   state_d = S_PUSHR;
            S_PUSHR: state_d = S_IF;
            S_POPN:  state_d = S_LDBN;
            S_LDBN:  state_d = S_EXEN;
            S_EXEN:  state_d = S_PUSHR;
            S_MEMRD: state_d = S_PUSHM;
            S_PUSHM: state_d = S_IF;
            S_POPM:  state_d = S_LDAM;
            S_LDAM:  state_d = S_MEMWR;
            S_MEMWR: state_d = S_IF;
            S_JMP:   state_d = S_IF;
            S_TOS:   state_d = S_LDAZ;
            S_LDAZ:  state_d = S_JZ;
            S_JZ:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        StackSrc    = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 1'b0;
        PCSrc       = 1'b0;
        ALUControl  = 2'b00;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 1'b1;
                    PCWrite = 1'b1;
                end
                S_POPA, S_POPN, S_POPM: pop = 1'b1;
                S_POPB: begin
                    ldA = 1'b1;
                    pop = 1'b1;
                end
                S_LDB, S_LDBN: ldB = 1'b1;
                // OPC[1:0] is still the ALU op here since IR only reloads in IF.
                S_EXE: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = OPC[1:0];
                end
                S_EXEN: begin
                    ALUSrcA    = 2'b01;
                    ALUControl = 2'b01;
                end
                S_PUSHR: push = 1'b1;
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_PUSHM: begin
                    push     = 1'b1;
                    StackSrc = 1'b1;
                end
                S_LDAM, S_LDAZ: ldA = 1'b1;
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_JMP: begin
                    PCSrc   = 1'b1;
                    PCWrite = 1'b1;
                end
                S_TOS: tos = 1'b1;
                S_JZ: begin
                    PCSrc       = 1'b1;
                    PCWriteCond = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mips_controller.sv
// Bench: controller drives a small behavioural stack datapath; results are compared per instruction
// against an instruction-level model (stack queue, data memory, PC) plus directed control checks.
module tb_stack_mips_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] OPC;
    logic       push, pop, tos, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       StackSrc, ldA, ldB, ALUSrcB, PCSrc;
    logic [1:0] ALUSrcA, ALUControl;

    always #5 clk = ~clk;

    stack_mips_controller dut (
        .clk(clk), .rst(rst), .OPC(OPC),
        .push(push), .pop(pop), .tos(tos),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .StackSrc(StackSrc), .ldA(ldA), .ldB(ldB),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl)
    );

    typedef struct packed {
        logic       push, pop, tos, pcw, pcwc, iord, mrd, mwr, irw, ssrc, lda, ldb;
        logic [1:0] asrca;
        logic       asrcb, pcsrc;
        logic [1:0] aluc;
    } ctl_t;

    ctl_t ctl;
    assign ctl = {push, pop, tos, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  StackSrc, ldA, ldB, ALUSrcA, ALUSrcB, PCSrc, ALUControl};

    // Datapath: Harvard split so instructions can be placed by the bench just before fetch.
    logic       dp_clr;
    logic [7:0] imem [32];
    logic [7:0] dmem [32];
    logic [7:0] dinit [32];
    logic [7:0] stk [16];
    logic [4:0] sp;
    logic [3:0] sp_m1;
    logic [7:0] dp_pc, ir, a_q, b_q, aluout, mdr, stk_out, alu_a, alu_b, alu_res;
    logic [4:0] addr;

    assign OPC   = ir[7:5];
    assign sp_m1 = 4'(sp - 5'd1);
    assign addr  = IorD ? ir[4:0] : dp_pc[4:0];
    assign alu_a = (ALUSrcA == 2'b00) ? dp_pc : (ALUSrcA == 2'b01) ? 8'hFF : a_q;
    assign alu_b = ALUSrcB ? 8'd1 : b_q;
    assign alu_res = (ALUControl == 2'b00) ? alu_a + alu_b :
                     (ALUControl == 2'b01) ? alu_a - alu_b :
                     (ALUControl == 2'b10) ? (alu_a & alu_b) : 8'h00;

    always @(posedge clk) begin
        if (dp_clr) begin
            sp <= '0; dp_pc <= '0; ir <= '0; a_q <= '0; b_q <= '0; stk_out <= '0;
            for (int i = 0; i < 32; i++) dmem[i] <= dinit[i];
        end else begin
            aluout <= alu_res;
            mdr    <= dmem[addr];
            if (IRWrite) ir <= imem[dp_pc[4:0]];
            if (MemWrite) dmem[addr] <= a_q;
            if (PCWrite || (PCWriteCond && a_q == 8'h00))
                dp_pc <= PCSrc ? {3'b000, ir[4:0]} : alu_res;
            if (ldA) a_q <= stk_out;
            if (ldB) b_q <= stk_out;
            if (pop) begin
                sp <= sp - 5'd1;
                stk_out <= stk[sp_m1];
            end else if (tos) begin
                stk_out <= stk[sp_m1];
            end else if (push) begin
                stk[sp[3:0]] <= StackSrc ? mdr : aluout;
                sp <= sp + 5'd1;
            end
        end
    end

    // Instruction-level reference model.
    logic [7:0] m_pc;
    logic [7:0] m_dmem [32];
    logic [7:0] m_stk [$];

    int   n_tests = 0;
    int   n_fail  = 0;
    ctl_t tr [$];
    ctl_t if_exp;
    logic [7:0] pc1;
    int   ncyc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd2: return 7;
            3'd3:             return 6;
            3'd4:             return 4;
            3'd5, 3'd7:       return 5;
            default:          return 3;
        endcase
    endfunction

    task automatic model_exec(input logic [7:0] ins);
        logic [7:0] a, b;
        logic [4:0] ad;
        ad   = ins[4:0];
        m_pc = m_pc + 8'd1;
        case (ins[7:5])
            3'd0, 3'd1, 3'd2: begin
                a = m_stk.pop_back();
                b = m_stk.pop_back();
                if (ins[7:5] == 3'd0)      m_stk.push_back(a + b);
                else if (ins[7:5] == 3'd1) m_stk.push_back(a - b);
                else                       m_stk.push_back(a & b);
            end
            3'd3: begin
                a = m_stk.pop_back();
                m_stk.push_back(~a);
            end
            3'd4: m_stk.push_back(m_dmem[ad]);
            3'd5: m_dmem[ad] = m_stk.pop_back();
            3'd6: m_pc = {3'b000, ad};
            default: if (m_stk[$] == 8'h00) m_pc = {3'b000, ad};
        endcase
    endtask

    // Entered at posedge+1 of an IF cycle; returns at posedge+1 of the next IF cycle.
    task automatic run_instr(input logic [7:0] ins);
        int         n;
        int         viol;
        bit         done;
        logic [7:0] pcb;
        pcb  = dp_pc;
        imem[dp_pc[4:0]] = ins;
        tr.delete();
        n    = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            tr.push_back(ctl);
            @(posedge clk);
            #1;
            n++;
            if (n == 1) pc1 = dp_pc;
            if (MemRead && IRWrite) done = 1'b1;
        end
        ncyc = n;
        check("no_timeout", 32'(done), 32'd1);
        model_exec(ins);
        viol = 0;
        foreach (tr[i])
            if ((int'(tr[i].push) + int'(tr[i].pop) + int'(tr[i].tos)) > 1 || (tr[i].mrd && tr[i].mwr))
                viol++;
        check("if_ctl", 32'(tr[0]), 32'(if_exp));
        check("pc_fetch", 32'(pc1), 32'(8'(pcb + 8'd1)));
        check("cycles", 32'(ncyc), 32'(exp_cycles(ins[7:5])));
        check("excl", 32'(viol), 32'd0);
        check("pc", 32'(dp_pc), 32'(m_pc));
        check("depth", 32'(sp), 32'(m_stk.size()));
        if (m_stk.size() > 0) check("top", 32'(stk[sp_m1]), 32'(m_stk[$]));
        if (ins[7:5] == 3'd5) check("pop_mem", 32'(dmem[ins[4:0]]), 32'(m_dmem[ins[4:0]]));
    endtask

    initial begin
        logic [7:0] pcb;
        logic [4:0] d0;
        logic [2:0] op;
        int         dep;
        int         nwr;
        int         wr_ok;

        rst    = 1'b1;
        dp_clr = 1'b1;
        if_exp = '0;
        if_exp.mrd = 1'b1; if_exp.irw = 1'b1; if_exp.asrcb = 1'b1; if_exp.pcw = 1'b1;
        for (int i = 0; i < 32; i++) dinit[i] = 8'($urandom_range(0, 255));
        dinit[20] = 8'h09; dinit[21] = 8'h03; dinit[22] = 8'h0F;
        dinit[23] = 8'h00; dinit[24] = 8'h05; dinit[25] = 8'h5A;
        for (int i = 0; i < 32; i++) m_dmem[i] = dinit[i];
        m_pc = 8'h00;

        @(posedge clk); #1 dp_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_instr(8'h94);                       // PUSH 20
        check("first_pc", 32'(pc1), 32'd1);
        run_instr(8'h95);                       // PUSH 21
        run_instr(8'h20);                       // SUB
        check("sub_top", 32'(stk[sp_m1]), 32'hFA);
        check("sub_cycles", 32'(ncyc), 32'd7);
        check("exe_srca", 32'(tr[5].asrca), 32'd2);
        check("exe_srcb", 32'(tr[5].asrcb), 32'd0);
        check("exe_aluc", 32'(tr[5].aluc), 32'd1);

        run_instr(8'h96);                       // PUSH 22
        run_instr(8'h60);                       // NOT
        check("not_top", 32'(stk[sp_m1]), 32'hF0);
        check("not_cycles", 32'(ncyc), 32'd6);
        check("exen_srca", 32'(tr[4].asrca), 32'd1);
        check("exen_aluc", 32'(tr[4].aluc), 32'd1);

        run_instr(8'h97);                       // PUSH 23 (zero)
        d0 = sp;
        run_instr(8'hEC);                       // JZ 12, taken
        check("jz_taken_pc", 32'(dp_pc), 32'd12);
        check("jz_depth", 32'(sp), 32'(d0));

        run_instr(8'h98);                       // PUSH 24 (nonzero)
        pcb = dp_pc;
        run_instr(8'hEC);                       // JZ 12, not taken
        check("jz_fall_pc", 32'(dp_pc), 32'(8'(pcb + 8'd1)));

        run_instr(8'h99);                       // PUSH 25
        run_instr(8'hBE);                       // POP 30
        check("pop30", 32'(dmem[30]), 32'h5A);
        nwr = 0; wr_ok = 0;
        foreach (tr[i]) if (tr[i].mwr) begin
            nwr++;
            if (tr[i].iord) wr_ok++;
        end
        check("memwr_pulses", 32'(nwr), 32'd1);
        check("memwr_iord", 32'(wr_ok), 32'd1);

        // Reset during LDB of an ADD: two pops already happened, the push must not.
        pcb = dp_pc;
        d0  = sp;
        imem[dp_pc[4:0]] = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("in_ldb", 32'(ctl.ldb), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_depth", 32'(sp), 32'(d0 - 5'd2));
        check("midrst_pc", 32'(dp_pc), 32'(8'(pcb + 8'd1)));
        m_pc = m_pc + 8'd1;
        void'(m_stk.pop_back());
        void'(m_stk.pop_back());

        for (int k = 0; k < 150; k++) begin
            dep = m_stk.size();
            do op = 3'($urandom_range(0, 7));
            while (!((op <= 3'd2 && dep >= 2) ||
                     ((op == 3'd3 || op == 3'd5 || op == 3'd7) && dep >= 1) ||
                     (op == 3'd4 && dep < 12) || op == 3'd6));
            run_instr({op, 5'($urandom_range(0, 31))});
        end

        // Unused encoding: outputs idle, next state IF.
        imem[dp_pc[4:0]] = 8'hC5;
        repeat (2) @(posedge clk);
        #1;
        check("in_jmp", 32'(ctl.pcsrc), 32'd1);
        force dut.state_q = 5'd31;
        @(negedge clk);
        check("illegal_ctl", 32'(ctl), 32'd0);
        release dut.state_q;
        @(posedge clk); #1;
        check("illegal_next", 32'(ctl), 32'(if_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_mips_controller.md
# stack_mips_controller

Multi-cycle control FSM for the stack-based 8-bit MIPS core. It consumes the 3-bit opcode from the datapath's instruction register. It drives every datapath control line (stack, PC, memory, IR, A/B registers, ALU muxes) so that each instruction runs as a fixed fetch/decode/execute sequence. It connects one-to-one with the datapath control ports.

## Interface
- Parameters: none. The opcode map and state sequences are fixed.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- OPC  in  3  opcode, IR[7:5]; stable from end of fetch until next fetch.
- push, pop, tos  out  1 each  stack controls.
- PCWrite, PCWriteCond  out  1 each  unconditional / zero-conditional PC load.
- IorD  out  1  memory address select: 0 = PC, 1 = IR[4:0].
- MemRead, MemWrite, IRWrite  out  1 each  memory read/write enables and IR load enable.
- StackSrc  out  1  stack input select: 0 = ALUOut, 1 = MDR.
- ldA, ldB  out  1 each  A/B register loads from stack output.
- ALUSrcA  out  2  ALU A select: 00 = PC (zero-extended), 01 = constant 255, 10 = A register.
- ALUSrcB  out  1  ALU B select: 0 = B register, 1 = constant 1.
- PCSrc  out  1  PC input select: 0 = ALU result, 1 = IR[4:0].
- ALUControl  out  2  ALU operation: 00 = add, 01 = sub, 10 = and.

## Operation
- Opcode map:
  - 000 ADD, 001 SUB, 010 AND, 011 NOT.
  - 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- Moore FSM with 19 states and a 5-bit state register. Each state's listed signals are 1; every unlisted output is 0 or 00.
- IF: MemRead, IRWrite, ALUSrcB=1, PCWrite (ALUSrcA=00, ALUControl=00, PCSrc=0, IorD=0). Next state is ID.
- ID: no outputs asserted. Next state by OPC:
  - 000/001/010 -> POPA
  - 011 -> POPN
  - 100 -> MEMRD
  - 101 -> POPM
  - 110 -> JMP
  - 111 -> TOS
- Arithmetic sequence (ADD/SUB/AND):
  - POPA: pop.
  - POPB: ldA, pop.
  - LDB: ldB.
  - EXE: ALUSrcA=10, ALUSrcB=0, ALUControl=OPC[1:0].
  - PUSHR: push, StackSrc=0.
  - Then IF.
  - Operand order: A = former top of stack, B = the element below it. SUB therefore computes top minus next.
- NOT sequence:
  - POPN: pop.
  - LDBN: ldB.
  - EXEN: ALUSrcA=01, ALUSrcB=0, ALUControl=01 (255 - B = ~B).
  - Then PUSHR.
- PUSH sequence:
  - MEMRD: IorD, MemRead.
  - PUSHM: push, StackSrc=1.
  - Then IF.
- POP sequence:
  - POPM: pop.
  - LDAM: ldA.
  - MEMWR: IorD, MemWrite.
  - Then IF.
- JMP: PCSrc, PCWrite. Then IF.
- JZ sequence:
  - TOS: tos (non-destructive read).
  - LDAZ: ldA.
  - JZ: PCSrc, PCWriteCond.
  - Then IF. JZ leaves the stack unchanged.
- Unused state encodings: all outputs 0, next state IF.
- At most one of push, pop, tos is asserted in any state.
- MemRead and MemWrite are never asserted together.

## Timing
- Reset value of every output is 0 while rst=1: outputs are gated by ~rst, and state is updated at the edge.
- The first edge with rst=1 sets state to IF. The first cycle after rst falls is IF.
- rst asserted in any state, mid-instruction: the next edge goes to IF and no further control pulse of that instruction issues. Datapath state already modified (stack pointer, memory) is not rolled back.
- Cycles per instruction, IF through the last state inclusive:
  - ADD/SUB/AND: 7
  - NOT: 6
  - PUSH: 4
  - POP: 5
  - JMP: 3
  - JZ: 5
- Stack data is registered: a value popped or read with tos in cycle n is loaded into A or B in cycle n+1. The FSM's one-cycle spacing relies on this.
- ALUOut and MDR capture every cycle. Their consumer (PUSHR, PUSHM) is always the cycle immediately after the producer (EXE/EXEN, MEMRD).
- OPC is sampled in ID. OPC[1:0] is re-read in EXE; it is valid because IRWrite is asserted only in IF.

## Test plan
- Reset, then release: outputs all 0 during rst. The first cycle after release is IF with MemRead=IRWrite=PCWrite=ALUSrcB=1, and PC advances 0 -> 1.
- Program PUSH 20; PUSH 21; SUB with mem[20]=9, mem[21]=3 -> stack top = 3-9 = 8'hFA. SUB spans exactly 7 cycles. EXE drives ALUSrcA=10, ALUSrcB=0, ALUControl=01.
- Top of stack 8'h0F, then NOT -> top becomes 8'hF0 after 6 cycles. EXEN drives ALUSrcA=01, ALUControl=01.
- Top of stack 8'h00, then JZ 12 -> PC=12 and stack depth unchanged. Repeat with top 8'h05 -> PC = JZ address + 1.
- POP 30 with top 8'h5A -> mem[30]=8'h5A. MemWrite is high for exactly one cycle (MEMWR) with IorD=1.
- Assert rst for one cycle during LDB of an ADD -> no push occurs and the FSM restarts at IF. Also force an illegal state encoding -> outputs 0, next state IF.
